// File: rtl/snake_pkg.sv
// Shared definitions for the snake body tracker slice: grid geometry,
// coordinate/length widths, direction encoding and start position defaults.
package snake_pkg;

  localparam int DEF_GRID_W  = 32;
  localparam int DEF_GRID_H  = 24;
  localparam int COORD_W     = 5;
  localparam int LEN_W       = 6;
  localparam int DEF_START_X = 16;
  localparam int DEF_START_Y = 12;

  // One-hot movement direction as produced by the head-movement stage.
  typedef enum logic [3:0] {
    DIR_UP    = 4'b0001,
    DIR_LEFT  = 4'b0010,
    DIR_RIGHT = 4'b0100,
    DIR_DOWN  = 4'b1000
  } dir_t;

  // True when a coordinate lies outside a grid of the given size.
  function automatic logic off_grid(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y,
                                    input int                 grid_w,
                                    input int                 grid_h);
    logic [COORD_W:0] xe;
    logic [COORD_W:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    return (xe >= (COORD_W+1)'(grid_w)) || (ye >= (COORD_W+1)'(grid_h));
  endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// Bus between the head/food stage, the renderer and the body tracker.
interface snake_body_tracker_if;
  import snake_pkg::*;

  logic               step;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic               grow;
  logic [COORD_W-1:0] query_x;
  logic [COORD_W-1:0] query_y;
  logic               occupied;
  logic               is_head;
  logic [LEN_W-1:0]   length;
  logic               game_over;
  logic               collide_wall;
  logic               collide_self;

  modport master (
    output step, head_x, head_y, grow, query_x, query_y,
    input  occupied, is_head, length, game_over, collide_wall, collide_self
  );

  modport slave (
    input  step, head_x, head_y, grow, query_x, query_y,
    output occupied, is_head, length, game_over, collide_wall, collide_self
  );

endinterface

// File: rtl/snake_seg_match.sv
// Combinational compare of one coordinate against every stored segment;
// indices at or beyond limit are masked so stale entries never hit.
module snake_seg_match
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic [COORD_W-1:0]              x,
  input  logic [COORD_W-1:0]              y,
  input  logic [MAX_LEN-1:0][COORD_W-1:0] seg_x,
  input  logic [MAX_LEN-1:0][COORD_W-1:0] seg_y,
  input  logic [LEN_W-1:0]                limit,
  output logic [MAX_LEN-1:0]              hit
);

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign hit[i] = (LEN_W'(i) < limit) && (seg_x[i] == x) && (seg_y[i] == y);
  end

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body tracker: keeps the ordered segment list, applies growth,
// detects wall/self collisions and answers renderer occupancy queries.
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int START_X  = DEF_START_X,
  parameter int START_Y  = DEF_START_Y
) (
  input logic                 clk,
  input logic                 rst,
  snake_body_tracker_if.slave bus
);

  logic [MAX_LEN-1:0][COORD_W-1:0] seg_x_r;
  logic [MAX_LEN-1:0][COORD_W-1:0] seg_y_r;
  logic [LEN_W-1:0]                length_r;
  logic                            grow_pend_r;
  logic                            game_over_r;
  logic                            collide_wall_r;
  logic                            collide_self_r;
  logic                            occupied_r;
  logic                            is_head_r;

  logic                            step_ok_s;
  logic                            eff_grow_s;
  logic [LEN_W-1:0]                self_limit_s;
  logic [MAX_LEN-1:0]              self_hit_s;
  logic [MAX_LEN-1:0]              query_hit_s;
  logic                            wall_s;
  logic                            self_s;

  assign step_ok_s  = bus.step & ~game_over_r;
  assign eff_grow_s = (bus.grow | grow_pend_r) & (length_r < LEN_W'(MAX_LEN));
  assign wall_s     = off_grid(bus.head_x, bus.head_y, GRID_W, GRID_H);
  assign self_s     = |self_hit_s;

  // The tail only vacates its cell when the snake is not growing.
  always_comb begin
    self_limit_s = length_r;
    if (eff_grow_s) begin
      self_limit_s = length_r;
    end else begin
      self_limit_s = length_r - LEN_W'(1);
    end
  end

  snake_seg_match #(.MAX_LEN(MAX_LEN)) u_self_match (
    .x     (bus.head_x),
    .y     (bus.head_y),
    .seg_x (seg_x_r),
    .seg_y (seg_y_r),
    .limit (self_limit_s),
    .hit   (self_hit_s)
  );

  snake_seg_match #(.MAX_LEN(MAX_LEN)) u_query_match (
    .x     (bus.query_x),
    .y     (bus.query_y),
    .seg_x (seg_x_r),
    .seg_y (seg_y_r),
    .limit (length_r),
    .hit   (query_hit_s)
  );

  // Segment storage, length, grow latch and sticky collision flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_x_r[i] <= COORD_W'(START_X - i);
          seg_y_r[i] <= COORD_W'(START_Y);
        end else begin
          seg_x_r[i] <= '0;
          seg_y_r[i] <= '0;
        end
      end
      length_r       <= LEN_W'(INIT_LEN);
      grow_pend_r    <= 1'b0;
      game_over_r    <= 1'b0;
      collide_wall_r <= 1'b0;
      collide_self_r <= 1'b0;
    end else if (step_ok_s) begin
      grow_pend_r <= 1'b0;
      if (wall_s || self_s) begin
        game_over_r    <= 1'b1;
        collide_wall_r <= collide_wall_r | wall_s;
        collide_self_r <= collide_self_r | self_s;
      end else begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x_r[i] <= seg_x_r[i-1];
          seg_y_r[i] <= seg_y_r[i-1];
        end
        seg_x_r[0] <= bus.head_x;
        seg_y_r[0] <= bus.head_y;
        length_r   <= length_r + LEN_W'(eff_grow_s);
      end
    end else if (bus.grow) begin
      grow_pend_r <= 1'b1;
    end else begin
      grow_pend_r <= grow_pend_r;
    end
  end

  // Renderer query: one-cycle registered occupancy against pre-step contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied_r <= 1'b0;
      is_head_r  <= 1'b0;
    end else begin
      occupied_r <= |query_hit_s;
      is_head_r  <= query_hit_s[0];
    end
  end

  assign bus.occupied     = occupied_r;
  assign bus.is_head      = is_head_r;
  assign bus.length       = length_r;
  assign bus.game_over    = game_over_r;
  assign bus.collide_wall = collide_wall_r;
  assign bus.collide_self = collide_self_r;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed self-checking bench for snake_body_tracker.
module tb_snake_body_tracker;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  snake_body_tracker_if bus ();

  snake_body_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a query, wait for the registered answer and compare it.
  task automatic query(input string tag, input int x, input int y, input int occ, input int hd);
    bus.query_x = 5'(x);
    bus.query_y = 5'(y);
    tick();
    check_value({tag, "_occ"}, int'(bus.occupied), occ);
    check_value({tag, "_head"}, int'(bus.is_head), hd);
  endtask

  task automatic do_step(input int x, input int y, input logic g);
    bus.step   = 1'b1;
    bus.head_x = 5'(x);
    bus.head_y = 5'(y);
    bus.grow   = g;
    tick();
    bus.step   = 1'b0;
    bus.grow   = 1'b0;
  endtask

  task automatic pulse_grow();
    bus.grow = 1'b1;
    tick();
    bus.grow = 1'b0;
  endtask

  task automatic check_flags(input string tag, input int len, input int go, input int cw, input int cs);
    check_value({tag, "_len"}, int'(bus.length), len);
    check_value({tag, "_over"}, int'(bus.game_over), go);
    check_value({tag, "_wall"}, int'(bus.collide_wall), cw);
    check_value({tag, "_self"}, int'(bus.collide_self), cs);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.step    = 1'b0;
    bus.grow    = 1'b0;
    bus.head_x  = 5'd0;
    bus.head_y  = 5'd0;
    bus.query_x = 5'd16;
    bus.query_y = 5'd12;

    // Reset state, with a query on the head cell held throughout.
    tick();
    tick();
    check_flags("rst", 3, 0, 0, 0);
    check_value("rst_occ", int'(bus.occupied), 0);
    check_value("rst_head", int'(bus.is_head), 0);
    @(negedge clk);
    rst = 1'b0;

    // Initial body (16,12),(15,12),(14,12).
    query("q_init_h", 16, 12, 1, 1);
    query("q_init_1", 15, 12, 1, 0);
    query("q_init_2", 14, 12, 1, 0);
    query("q_init_x", 13, 12, 0, 0);

    // Plain step; the query on the step cycle still sees the old tail.
    bus.query_x = 5'd14;
    bus.query_y = 5'd12;
    do_step(17, 12, 1'b0);
    check_value("pre_step_occ", int'(bus.occupied), 1);
    query("q_old_tail", 14, 12, 0, 0);
    query("q_new_head", 17, 12, 1, 1);
    check_flags("step1", 3, 0, 0, 0);

    // Latched grow applied to a later step keeps the tail.
    pulse_grow();
    tick();
    do_step(18, 12, 1'b0);
    check_flags("grow_late", 4, 0, 0, 0);
    query("q_kept_tail", 15, 12, 1, 0);

    // Grow in the same cycle as the step adds exactly one.
    do_step(19, 12, 1'b1);
    check_flags("grow_same", 5, 0, 0, 0);
    do_step(20, 12, 1'b0);
    check_flags("pend_consumed", 5, 0, 0, 0);

    // Two grows before one step collapse into a single segment.
    pulse_grow();
    pulse_grow();
    do_step(21, 12, 1'b0);
    check_flags("grow_collapse", 6, 0, 0, 0);
    do_step(22, 12, 1'b0);
    check_flags("grow_once", 6, 0, 0, 0);

    // Reversal into the neck: body freezes and further steps are ignored.
    do_step(21, 12, 1'b0);
    check_flags("reverse", 6, 1, 0, 1);
    query("q_frozen_head", 22, 12, 1, 1);
    do_step(23, 12, 1'b1);
    check_flags("ignored", 6, 1, 0, 1);
    query("q_ignored", 23, 12, 0, 0);

    // Reset asserted mid-cycle clears everything without waiting for a clock.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_flags("async_rst", 3, 0, 0, 0);
    check_value("async_rst_occ", int'(bus.occupied), 0);
    @(negedge clk);
    rst = 1'b0;

    // Tail chase in a 2x2 square.
    do_step(16, 11, 1'b1);
    do_step(15, 11, 1'b0);
    check_flags("square", 4, 0, 0, 0);
    do_step(15, 12, 1'b0);
    check_flags("tail_chase", 4, 0, 0, 0);
    query("q_chase_head", 15, 12, 1, 1);
    do_step(16, 12, 1'b1);
    check_flags("tail_chase_grow", 4, 1, 0, 1);

    // Wall at y = GRID_H.
    apply_reset();
    do_step(16, 24, 1'b0);
    check_flags("wall_y24", 3, 1, 1, 0);
    query("q_wall_frozen", 16, 12, 1, 1);

    // Wall from y underflow (0 - 1 = 31).
    apply_reset();
    do_step(16, 31, 1'b0);
    check_flags("wall_y31", 3, 1, 1, 0);

    // x underflow to 31 is a legal cell.
    apply_reset();
    do_step(31, 12, 1'b0);
    check_flags("x_wrap", 3, 0, 0, 0);
    query("q_x_wrap", 31, 12, 1, 1);

    // Wall and self together: head lands on a body cell that is also off-grid is
    // impossible, so check a wall step while growing does not touch length.
    do_step(31, 24, 1'b1);
    check_flags("wall_grow", 3, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_body_tracker.md
Name: snake_body_tracker

Overview:
- Downstream of the head-movement/food stage.
- Consumes each newly computed head coordinate and maintains the full ordered list of body segments on the 32x24 grid.
- Detects self-collision and wall collision, and tracks snake length, including growth when food is eaten.
- Answers per-cell occupancy queries from the VGA renderer with fixed 1-cycle latency.

Parameters:
- MAX_LEN, 32, maximum segment count (storage depth); legal range 4..63.
- INIT_LEN, 3, length after reset; must be >= 2 and <= MAX_LEN.
- GRID_W, 32, grid columns; legal x is 0..GRID_W-1.
- GRID_H, 24, grid rows; legal y is 0..GRID_H-1.
- START_X, 16, head x after reset.
- START_Y, 12, head y after reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- step  input  1  one-cycle pulse: head_x/head_y hold the new head for this move.
- head_x  input  5  new head column, sampled only when step=1.
- head_y  input  5  new head row, sampled only when step=1.
- grow  input  1  one-cycle pulse: food eaten, so the body lengthens by one on the current or next step.
- query_x  input  5  renderer cell column.
- query_y  input  5  renderer cell row.
- occupied  output  1  registered: query cell is held by any live segment.
- is_head  output  1  registered: query cell is segment 0.
- length  output  6  current live segment count.
- game_over  output  1  sticky collision flag.
- collide_wall  output  1  sticky: game ended on a wall hit.
- collide_self  output  1  sticky: game ended on a body hit.

Behaviour:
- Storage
  - seg_x[i], seg_y[i] for i = 0..MAX_LEN-1; index 0 is the head.
  - Live segments are indices < length. Entries at or beyond length hold stale data and are masked from every comparison.
- Reset (async, rst=1)
  - seg[i] = (START_X - i, START_Y) for i < INIT_LEN; all other entries = 0.
  - length = INIT_LEN.
  - game_over, collide_wall, collide_self, occupied, is_head = 0.
  - grow_pend = 0.
  - Reset asserted mid-step abandons that step; nothing is partially shifted.
- Grow latch
  - grow=1 sets grow_pend.
  - grow_pend clears on the next accepted step, which consumes it.
  - grow and step in the same cycle: the grow applies to that step.
  - Multiple grows before a step collapse into one.
- Accepted step (step=1 and game_over=0)
  - eff_grow = (grow | grow_pend) & (length < MAX_LEN). Grow at MAX_LEN is discarded and grow_pend is cleared.
  - Wall check: head_x >= GRID_W or head_y >= GRID_H. This covers underflow wrap, since 0-1 = 31 >= GRID_W is false but 31 >= 24 is true for y only.
    - x underflow lands at 31, which is legal. Wall-on-x therefore relies on the upstream stage; x wraps silently on the 32-wide grid.
  - Self check: head equals seg[i] for any i < length-1 when eff_grow=0, or any i < length when eff_grow=1. The departing tail is excluded only when it actually moves.
  - On any collision:
    - game_over <= 1, plus the matching sticky flag (both flags may set together).
    - No shift; the body freezes.
  - Otherwise:
    - seg[i] <= seg[i-1] for i >= 1, and seg[0] <= head.
    - length <= length + eff_grow.
- Steps while game_over=1 are ignored. Only rst clears game_over.
- Query path
  - occupied/is_head register the combinational match of (query_x, query_y) against live segments.
  - Latency is exactly 1 cycle and runs every cycle, independent of step.
  - On a step cycle the query sees pre-step contents.
- Length never exceeds MAX_LEN and never decreases.

Decomposition:
- Shared package snake_pkg holds:
  - GRID_W, GRID_H, coordinate width (5), length width (6).
  - Direction one-hot constants (UP 0001, LEFT 0010, RIGHT 0100, DOWN 1000).
  - START_X/START_Y defaults.
- One sub-module: snake_seg_match.
  - Purely combinational.
  - Inputs: coordinate, the array, a live-count limit.
  - Output: a per-index hit vector.
  - Instantiated twice: once for self-collision with a step-dependent limit, once for query occupancy with limit = length.

Test Plan:
- Reset then query (16,12),(15,12),(14,12),(13,12) -> occupied 1,1,1,0 one cycle later; is_head only for (16,12); length=3.
- Step head (17,12) without grow -> (14,12) no longer occupied; length=3; (17,12) is_head.
- grow pulse then step (18,12) two cycles later -> length=4; tail (15,12) kept; a grow+step in the same cycle also gives +1, not +2.
- Step head (17,12) from body (18,12),(17,12),(16,12),(15,12) (reversal) -> game_over=1, collide_self=1, no shift; further steps ignored.
- Tail-chase: length 4 in a square, new head equals the current tail with no grow -> no collision; the same move with grow=1 -> collide_self=1.
- Step head_y=24 (and separately head_y=31 from underflow) -> game_over=1, collide_wall=1; then rst mid-run -> all outputs return to reset values immediately.
